gen_multitap: RTL

- Parametrised multi-player adapter for one controller port (Team-Player-class multitap).
- Presents NPAD pads to the host over a TH/TR/TL nibble-stream handshake.
- Sits between the port's CTL/DATA resolution logic in the I/O block and the pad inputs.
- Generalises the single-pad TH-counter protocol to N pads with mixed 3/6-button types, frame-consistent snapshots, a programmable acknowledge delay and a session timeout.

---
 rtl/gen_multitap.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/gen_multitap.sv
// gen_multitap: multi-player adapter (Team-Player-class multitap) for one controller port.
// The host selects the tap by pulling TH low. Each TR toggle requests the next nibble of
// the frame, and the tap answers by setting TL to the new TR level after a programmable delay.
// A frame is a fixed header, then one type nibble per pad, then the data nibbles of each
// present pad. Button and type inputs are snapshotted on the TH fall, so a frame is
// consistent even if the pads change while it streams.
//
// Ports:
//   CLK       system clock
//   RESET_N   asynchronous active-low reset
//   CE        clock enable; all state advances only when CE=1
//   PAD_TYPE  2 bits per pad: 00/11 absent, 01 3-button, 10 6-button
//   BTN       12 bits per pad, active-high {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}
//   TH, TR    resolved port pin levels (asynchronous to CE, synchronised here)
//   DO        port read value {0,TH,TR,TL,nibble}
module gen_multitap #(
  parameter int unsigned NPAD    = 4,
  parameter int unsigned ACK_DLY = 40,
  parameter int unsigned TMO     = 11600
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                CE,
  input  logic [2*NPAD-1:0]   PAD_TYPE,
  input  logic [12*NPAD-1:0]  BTN,
  input  logic                TH,
  input  logic                TR,
  output logic [7:0]          DO
);

  localparam int unsigned SeqLen = 2 + 4 * NPAD;
  localparam int unsigned IdxW   = $clog2(SeqLen + 1);
  localparam int unsigned TmoW   = $clog2(TMO + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReady = 2'd1;
  localparam logic [1:0] StAck   = 2'd2;

  logic                th_s1_q, th_s2_q, th_s3_q;
  logic                tr_s1_q, tr_s2_q;
  logic [1:0]          state_q, state_d;
  logic                tl_q, tl_d;
  logic [3:0]          nibble_q, nibble_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                trq_q, trq_d;
  logic [7:0]          ack_cnt_q, ack_cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [12*NPAD-1:0]  snap_btn_q, snap_btn_d;
  logic [2*NPAD-1:0]   snap_type_q, snap_type_d;

  logic [3:0]          seq [SeqLen];
  logic [3:0]          seq_nib;
  logic                th_fall;
  logic                ack_done;

  assign th_fall = th_s3_q & ~th_s2_q;
  // The READY cycle that detects the request counts as the first delay cycle, so TL
  // follows the TR edge by ACK_DLY cycles past the synchroniser.
  assign ack_done = ({1'b0, ack_cnt_q} + 9'd2) >= 9'(ACK_DLY);

  // Frame contents built from the snapshot; unused tail entries read as 0xF.
  always_comb begin
    logic [IdxW-1:0] pos;
    logic [1:0]      ptype;
    logic [11:0]     b;
    for (int unsigned i = 0; i < SeqLen; i++) seq[i] = 4'hF;
    seq[0] = 4'h0;
    seq[1] = 4'h0;
    pos    = IdxW'(2 + NPAD);
    ptype  = 2'b00;
    b      = 12'h000;
    for (int unsigned k = 0; k < NPAD; k++) begin
      ptype = snap_type_q[2*k +: 2];
      unique case (ptype)
        2'b01:   seq[IdxW'(2 + k)] = 4'h0;
        2'b10:   seq[IdxW'(2 + k)] = 4'h1;
        default: seq[IdxW'(2 + k)] = 4'hF;
      endcase
    end
    for (int unsigned k = 0; k < NPAD; k++) begin
      ptype = snap_type_q[2*k +: 2];
      b     = snap_btn_q[12*k +: 12];
      if (ptype == 2'b01 || ptype == 2'b10) begin
        seq[pos] = ~b[3:0];
        pos      = pos + IdxW'(1);
        seq[pos] = ~{b[7], b[4], b[6], b[5]};
        pos      = pos + IdxW'(1);
        if (ptype == 2'b10) begin
          seq[pos] = ~{b[8], b[9], b[10], b[11]};
          pos      = pos + IdxW'(1);
        end
      end
    end
  end

  assign seq_nib = (idx_q < IdxW'(SeqLen)) ? seq[idx_q] : 4'hF;

  always_comb begin
    state_d     = state_q;
    tl_d        = tl_q;
    nibble_d    = nibble_q;
    idx_d       = idx_q;
    trq_d       = trq_q;
    ack_cnt_d   = ack_cnt_q;
    tmo_d       = tmo_q;
    snap_btn_d  = snap_btn_q;
    snap_type_d = snap_type_q;
    unique case (state_q)
      StIdle: begin
        tl_d     = 1'b1;
        nibble_d = 4'h3;
        tmo_d    = '0;
        if (th_fall) begin
          snap_btn_d  = BTN;
          snap_type_d = PAD_TYPE;
          idx_d       = '0;
          tl_d        = tr_s2_q;
          nibble_d    = 4'hF;
          state_d     = StReady;
        end
      end
      StReady: begin
        if (th_s2_q) begin
          state_d  = StIdle;
          tl_d     = 1'b1;
          nibble_d = 4'h3;
          tmo_d    = '0;
        end else if (tr_s2_q != tl_q) begin
          trq_d     = tr_s2_q;
          ack_cnt_d = '0;
          state_d   = StAck;
        end else if (tmo_q == TmoW'(TMO - 1)) begin
          state_d  = StIdle;
          tl_d     = 1'b1;
          nibble_d = 4'h3;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StAck: begin
        if (th_s2_q) begin
          // Abort: the pending acknowledge is dropped.
          state_d  = StIdle;
          tl_d     = 1'b1;
          nibble_d = 4'h3;
          tmo_d    = '0;
        end else if (ack_done) begin
          nibble_d = seq_nib;
          tl_d     = trq_q;
          if (idx_q != '1) idx_d = idx_q + IdxW'(1);
          tmo_d    = '0;
          state_d  = StReady;
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = StIdle;
        tl_d     = 1'b1;
        nibble_d = 4'h3;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      th_s1_q     <= 1'b1;
      th_s2_q     <= 1'b1;
      th_s3_q     <= 1'b1;
      tr_s1_q     <= 1'b1;
      tr_s2_q     <= 1'b1;
      state_q     <= StIdle;
      tl_q        <= 1'b1;
      nibble_q    <= 4'h3;
      idx_q       <= '0;
      trq_q       <= 1'b1;
      ack_cnt_q   <= '0;
      tmo_q       <= '0;
      snap_btn_q  <= '0;
      snap_type_q <= '0;
    end else if (CE) begin
      th_s1_q     <= TH;
      th_s2_q     <= th_s1_q;
      th_s3_q     <= th_s2_q;
      tr_s1_q     <= TR;
      tr_s2_q     <= tr_s1_q;
      state_q     <= state_d;
      tl_q        <= tl_d;
      nibble_q    <= nibble_d;
      idx_q       <= idx_d;
      trq_q       <= trq_d;
      ack_cnt_q   <= ack_cnt_d;
      tmo_q       <= tmo_d;
      snap_btn_q  <= snap_btn_d;
      snap_type_q <= snap_type_d;
    end
  end

  assign DO = {1'b0, TH, TR, tl_q, nibble_q};

endmodule
